// File: rtl/exwb_stage_pkg.sv
// Shared constants and types for the execute/write-back stage and its helpers.
// Bit numbering is big-endian: bit 0 is the MSB and byte 0 occupies bits [0:7].
package exwb_stage_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int BEN_W  = 8;
    localparam int PPP_W  = 3;

    // Participation codes; 101-111 are reserved and decode to an empty mask.
    localparam logic [0:PPP_W-1] PPP_ALL   = 3'b000;
    localparam logic [0:PPP_W-1] PPP_UPPER = 3'b001;
    localparam logic [0:PPP_W-1] PPP_LOWER = 3'b010;
    localparam logic [0:PPP_W-1] PPP_EVEN  = 3'b011;
    localparam logic [0:PPP_W-1] PPP_ODD   = 3'b100;

    // Element width codes shared with the ALU.
    typedef enum logic [0:1] {
        WW_BYTE   = 2'b00,
        WW_HALF   = 2'b01,
        WW_WORD   = 2'b10,
        WW_DOUBLE = 2'b11
    } ww_t;

    typedef struct packed {
        logic [0:ADDR_W-1] addr;
        logic [0:DATA_W-1] data;
        logic [0:BEN_W-1]  ben;
    } wb_entry_t;

endpackage

// File: rtl/exwb_stage_ppp_decode.sv
// Purpose: map a 3-bit participation field to a per-byte enable mask plus an illegal flag.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no state and no handshake.
module ppp_decode
    import exwb_stage_pkg::*;
(
    input  logic [0:PPP_W-1] ppp,
    output logic [0:BEN_W-1] ben,
    output logic             illegal
);

    always_comb begin
        ben     = '0;
        illegal = 1'b0;
        case (ppp)
            PPP_ALL:   ben = 8'b11111111;
            PPP_UPPER: ben = 8'b11110000;
            PPP_LOWER: ben = 8'b00001111;
            PPP_EVEN:  ben = 8'b10101010;
            PPP_ODD:   ben = 8'b01010101;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/exwb_stage.sv
// Purpose: register ALU/load result with byte enables and hand it to the register file.
// Latency: one cycle from acceptance to wb_valid; throughput one entry per cycle.
// Backpressure: single holding entry; ex_ready drops only while the entry is stalled.
module exwb_stage
    import exwb_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [0:DATA_W-1] alu_out,
    input  logic [0:DATA_W-1] mem_rd_data,
    input  logic              mem_to_reg,
    input  logic              reg_wr,
    input  logic [0:ADDR_W-1] rD,
    input  logic [0:PPP_W-1]  PPP,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [0:ADDR_W-1] wb_addr,
    output logic [0:DATA_W-1] wb_data,
    output logic [0:BEN_W-1]  wb_byte_en,
    output logic              fwd_valid,
    output logic [0:ADDR_W-1] fwd_addr,
    output logic [0:DATA_W-1] fwd_data,
    output logic              ppp_err,
    output logic [CNT_W-1:0]  commit_cnt
);

    logic             valid_q;
    wb_entry_t        entry_q;
    logic             ppp_err_q;
    logic [CNT_W-1:0] cnt_q;

    logic [0:BEN_W-1] dec_ben;
    logic             dec_illegal;
    logic             load;
    logic             commit;

    ppp_decode u_ppp_decode (
        .ppp     (PPP),
        .ben     (dec_ben),
        .illegal (dec_illegal)
    );

    assign ex_ready = !valid_q || wb_ready;
    assign load     = ex_valid && ex_ready && reg_wr;
    assign commit   = valid_q && wb_ready;

    // A load on the same edge as a commit simply overwrites the departing entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            entry_q <= '0;
        end else if (load) begin
            valid_q      <= 1'b1;
            entry_q.addr <= rD;
            entry_q.data <= mem_to_reg ? mem_rd_data : alu_out;
            entry_q.ben  <= dec_ben;
        end else if (commit) begin
            valid_q <= 1'b0;
        end
    end

    // Illegal codes still occupy a slot and commit as a no-op write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ppp_err_q <= 1'b0;
        end else if (load && dec_illegal) begin
            ppp_err_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (commit) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign wb_valid   = valid_q;
    assign wb_addr    = entry_q.addr;
    assign wb_data    = entry_q.data;
    assign wb_byte_en = entry_q.ben;

    assign fwd_valid  = valid_q;
    assign fwd_addr   = entry_q.addr;
    assign fwd_data   = entry_q.data;

    assign ppp_err    = ppp_err_q;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_exwb_stage.sv
// Randomized and directed bench for exwb_stage against a queue-based reference model.
module tb_exwb_stage;

    localparam int CW = 4;

    logic          clk;
    logic          reset;
    logic          ex_valid;
    logic          ex_ready;
    logic [0:63]   alu_out;
    logic [0:63]   mem_rd_data;
    logic          mem_to_reg;
    logic          reg_wr;
    logic [0:4]    rD;
    logic [0:2]    PPP;
    logic          wb_valid;
    logic          wb_ready;
    logic [0:4]    wb_addr;
    logic [0:63]   wb_data;
    logic [0:7]    wb_byte_en;
    logic          fwd_valid;
    logic [0:4]    fwd_addr;
    logic [0:63]   fwd_data;
    logic          ppp_err;
    logic [CW-1:0] commit_cnt;

    exwb_stage #(.CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .alu_out     (alu_out),
        .mem_rd_data (mem_rd_data),
        .mem_to_reg  (mem_to_reg),
        .reg_wr      (reg_wr),
        .rD          (rD),
        .PPP         (PPP),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_byte_en  (wb_byte_en),
        .fwd_valid   (fwd_valid),
        .fwd_addr    (fwd_addr),
        .fwd_data    (fwd_data),
        .ppp_err     (ppp_err),
        .commit_cnt  (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [0:4]  addr;
        logic [0:63] data;
        logic [0:7]  ben;
    } ent_t;

    ent_t    pend[$];
    int      exp_cnt;
    logic    exp_err;
    int      n_chk;
    int      n_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [0:7] ref_ben(input logic [0:2] p);
        case (p)
            3'd0:    return 8'hFF;
            3'd1:    return 8'hF0;
            3'd2:    return 8'h0F;
            3'd3:    return 8'hAA;
            3'd4:    return 8'h55;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_outputs();
        logic [3:0] c;
        c = exp_cnt[3:0];
        check("ex_ready", ex_ready, pend.size() == 0 || wb_ready);
        check("wb_valid", wb_valid, pend.size() != 0);
        check("fwd_valid", fwd_valid, pend.size() != 0);
        if (pend.size() != 0) begin
            check("wb_addr", wb_addr, pend[0].addr);
            check("wb_data", wb_data, pend[0].data);
            check("wb_byte_en", wb_byte_en, pend[0].ben);
            check("fwd_addr", fwd_addr, pend[0].addr);
            check("fwd_data", fwd_data, pend[0].data);
        end
        check("ppp_err", ppp_err, exp_err);
        check("commit_cnt", commit_cnt, c);
    endtask

    // Reference behaviour at a rising edge: the register file drains first, then execute refills.
    task automatic model_edge();
        ent_t e;
        logic acc;
        acc = ex_valid && (pend.size() == 0 || wb_ready);
        if (pend.size() != 0 && wb_ready) begin
            void'(pend.pop_front());
            exp_cnt = (exp_cnt + 1) % 16;
        end
        if (acc && reg_wr) begin
            e.addr = rD;
            e.data = mem_to_reg ? mem_rd_data : alu_out;
            e.ben  = ref_ben(PPP);
            pend.push_back(e);
            if (PPP > 3'd4) exp_err = 1'b1;
        end
    endtask

    task automatic cycle(input logic ev, input logic [0:63] alu, input logic [0:63] mem,
                         input logic m2r, input logic rw, input logic [0:4] rd,
                         input logic [0:2] ppp, input logic wrdy);
        ex_valid    = ev;
        alu_out     = alu;
        mem_rd_data = mem;
        mem_to_reg  = m2r;
        reg_wr      = rw;
        rD          = rd;
        PPP         = ppp;
        wb_ready    = wrdy;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [0:63] r64;
        logic [0:2]  rp;
        logic        rrw;
        n_chk = 0;
        n_err = 0;
        exp_cnt = 0;
        exp_err = 1'b0;
        reset = 1'b1;
        ex_valid = 1'b0; alu_out = '0; mem_rd_data = '0; mem_to_reg = 1'b0;
        reg_wr = 1'b0; rD = '0; PPP = '0; wb_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_addr", wb_addr, 5'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_wb_byte_en", wb_byte_en, 8'h00);
        check("rst_ppp_err", ppp_err, 1'b0);
        check("rst_commit_cnt", commit_cnt, 4'd0);
        check("rst_ex_ready", ex_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single accept, then confirm the registered entry with literal values.
        cycle(1, 64'hFFFFFFFF_00000000, 64'd0, 0, 1, 5'd7, 3'b001, 1);
        #1;
        check("t1_wb_valid", wb_valid, 1'b1);
        check("t1_wb_addr", wb_addr, 5'd7);
        check("t1_wb_data", wb_data, 64'hFFFFFFFF_00000000);
        check("t1_wb_byte_en", wb_byte_en, 8'hF0);
        cycle(0, 64'd0, 64'd0, 0, 0, 5'd0, 3'b000, 1);
        check("t1_commit_cnt", commit_cnt, 4'd1);

        // PPP sweep including an illegal code, then legal codes after it.
        for (int i = 0; i < 5; i++) cycle(1, 64'd15, 64'd0, 0, 1, 5'(i), 3'(i), 1);
        cycle(1, 64'd15, 64'd0, 0, 1, 5'd9, 3'b110, 1);
        cycle(1, 64'd15, 64'd0, 0, 1, 5'd0, 3'b000, 1);
        cycle(1, 64'd15, 64'd0, 0, 1, 5'd1, 3'b011, 1);
        cycle(0, 64'd0, 64'd0, 0, 0, 5'd0, 3'b000, 1);

        // Back-pressure with a new instruction waiting, then release.
        cycle(1, 64'h1111, 64'd0, 0, 1, 5'd3, 3'b000, 1);
        for (int i = 0; i < 3; i++) cycle(1, 64'h2222, 64'd0, 0, 1, 5'd4, 3'b010, 0);
        cycle(1, 64'h2222, 64'd0, 0, 1, 5'd4, 3'b010, 1);
        cycle(0, 64'd0, 64'd0, 0, 0, 5'd0, 3'b000, 1);

        // Streaming with alternating load/ALU source, and a bubble.
        for (int i = 0; i < 4; i++) cycle(1, 64'd14, 64'd400, i[0], 1, 5'd10, 3'b000, 1);
        cycle(1, 64'd77, 64'd0, 0, 0, 5'd11, 3'b000, 1);
        cycle(0, 64'd0, 64'd0, 0, 0, 5'd0, 3'b000, 1);

        // Random traffic; the 4-bit counter wraps many times.
        for (int i = 0; i < 400; i++) begin
            r64 = {$urandom, $urandom};
            rrw = ($urandom_range(0, 3) != 0);
            rp  = rrw ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 4));
            cycle($urandom_range(0, 3) != 0, r64, {$urandom, $urandom},
                  $urandom_range(0, 1) == 1, rrw, 5'($urandom_range(0, 31)), rp,
                  $urandom_range(0, 9) < 7);
        end

        // Asynchronous reset while an entry is stalled.
        cycle(1, 64'hABCD, 64'd0, 0, 1, 5'd21, 3'b000, 1);
        cycle(0, 64'd0, 64'd0, 0, 0, 5'd0, 3'b000, 0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_wb_valid", wb_valid, 1'b0);
        check("arst_wb_addr", wb_addr, 5'd0);
        check("arst_wb_data", wb_data, 64'd0);
        check("arst_wb_byte_en", wb_byte_en, 8'h00);
        check("arst_ppp_err", ppp_err, 1'b0);
        check("arst_commit_cnt", commit_cnt, 4'd0);
        check("arst_ex_ready", ex_ready, 1'b1);
        pend.delete();
        exp_cnt = 0;
        exp_err = 1'b0;
        wb_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) cycle(0, 64'd0, 64'd0, 0, 0, 5'd0, 3'b000, 1);
        cycle(1, 64'd5, 64'd0, 0, 1, 5'd2, 3'b100, 1);
        cycle(0, 64'd0, 64'd0, 0, 0, 5'd0, 3'b000, 1);
        cycle(0, 64'd0, 64'd0, 0, 0, 5'd0, 3'b000, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
